i2cs: RTL
=========

# i2cs

I2C target (slave) with a small register file, used as the bus-side counterpart of the `i2cm` controller. It provides a second on-bus I2C device next to the EEPROM model, and serves as the synthesizable peripheral that `i2cm` firmware talks to. It oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address and supports pointer-addressed burst writes and reads with auto-increment. It does not stretch the clock.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit device address matched against the first byte after START.
- `AW`, 4, register pointer width; depth = 2**AW bytes.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, active-high, asynchronous assert.
- `scl_i`  in  1  SCL pin level (tristate-resolved bus).
- `sda_i`  in  1  SDA pin level.
- `sda_o`  out  1  constant 0 (open-drain data value).
- `sda_oe`  out  1  1 = pull SDA low.
- `busy`  out  1  high while state != IDLE.
- `wr_en`  out  1  one-cycle pulse when a data byte is committed to the register file.
- `wr_addr`  out  AW  register index written on `wr_en`.
- `wr_data`  out  8  byte written on `wr_en`.

## Operation
- Input sync: 2-FF synchronizer per line plus one history flop; all reset to 1. Edges/conditions are evaluated on synced values only.
- START = synced SDA 1->0 while synced SCL = 1; STOP = SDA 0->1 while SCL = 1. START (including repeated START) from any state -> DEVADDR, bit count cleared. STOP from any state -> IDLE, `sda_oe` = 0.
- Data bits sampled on SCL rising edge, MSB first. `sda_oe` changes only on SCL falling edge (except STOP/reset, which release immediately).
- States: IDLE, DEVADDR, DEV_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- DEVADDR: after 8th bit, if byte[7:1] == DEV_ADDR -> DEV_ACK, else -> IDLE (ignores bus until next START).
- DEV_ACK: `sda_oe` = 1 from next SCL fall to the following SCL fall. Then R/W=0 -> PTR; R/W=1 -> load `shreg` = mem[ptr], ptr = ptr+1, -> RDATA.
- PTR: 8th bit -> ptr = byte[AW-1:0] (upper bits ignored), PTR_ACK (ack as above) -> WDATA.
- WDATA: on 8th-bit SCL rise: mem[ptr] = byte, `wr_en` pulse with `wr_addr` = ptr, `wr_data` = byte, ptr = ptr+1; -> WDATA_ACK (ack) -> WDATA.
- RDATA: on each SCL fall `sda_oe` = ~shreg[7], shift left; after 8 bits, release at SCL fall -> RDATA_ACK.
- RDATA_ACK: sample SDA on SCL rise. 0 (ACK) -> load mem[ptr], ptr = ptr+1, -> RDATA. 1 (NACK) -> IDLE.
- Pointer increments modulo 2**AW (15 -> 0 for AW=4) for both read and write; ptr persists across transactions and STOP.
- Register file: 2**AW x 8, reset to 0x00.

## Timing
- Reset values: `sda_o` = 0, `sda_oe` = 0, `busy` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, ptr = 0, state IDLE. Reset mid-transfer aborts immediately; no partial write.
- Pin-to-detect latency: 3 `clk` from pin change to detected edge/condition.
- `sda_oe` update: 1 `clk` after detected SCL fall (≤4 `clk` after pin fall).
- `wr_en` asserts 1 `clk` after detected 8th SCL rise of a data byte, exactly 1 cycle wide.
- SCL high and low phases must each be ≥ 4 `clk`; SDA setup to SCL rise ≥ 4 `clk`.
- START and data edge in the same sample: START/STOP take priority over bit sampling.

## Test plan
- Write: START, 0xA0, ptr 0x03, data 0x11, 0x22, STOP -> ACK on all 4 bytes; `wr_en` pulses with (3, 0x11) then (4, 0x22); ptr = 5.
- Random read with repeated START: START 0xA0, ptr 0x03, Sr 0xA1, read 2 bytes (ACK, NACK), STOP -> returns 0x11, 0x22; `sda_oe` released after NACK; `busy` = 0 after STOP.
- Address mismatch: START 0xA2, 0x55 -> no ACK (`sda_oe` stays 0), no `wr_en`, `busy` returns 0 after the 8th bit.
- Wrap: write ptr 0x0F, data 0xAA, 0xBB -> `wr_addr` 15 then 0; reading from ptr 0x0F returns 0xAA, 0xBB.
- Pointer upper bits: ptr byte 0xF2 -> treated as 2.
- Reset mid-read: assert `rst` while driving a 0 bit -> `sda_oe` = 0 same cycle, state IDLE; subsequent read from ptr 0 returns 0x00.

Source files
------------

// File: rtl/i2cs.sv
// I2C target with a 2**AW-byte register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk; the target never stretches the clock.
module i2cs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);
    localparam int DEPTH = 1 << AW;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEVADDR   = 4'd1;
    localparam logic [3:0] S_DEV_ACK   = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_hist_q, sda_hist_q;
    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_byte, rd_byte;
    logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          oe_q, oe_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          mem_we;
    logic [7:0]    mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_hist_q & sda_s;
    assign rx_byte   = {shreg_q[6:0], sda_s};
    assign rd_byte   = mem_q[ptr_q];
    assign ptr_inc   = ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else if (start_det) begin
            // A driven SDA would block any START, so releasing here only guards odd masters.
            state_d = S_DEVADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_DEVADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == S_DEVADDR) begin
                                state_d = (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IDLE;
                            end else if (state_q == S_PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                mem_we    = 1'b1;
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_inc;
                                state_d   = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_DEV_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    // First fall drives the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_WDATA;
                            if (state_q == S_DEV_ACK) begin
                                if (shreg_q[0]) begin
                                    // The fall that ends the ACK also presents read bit 7.
                                    oe_d    = ~rd_byte[7];
                                    shreg_d = {rd_byte[6:0], 1'b0};
                                    ptr_d   = ptr_inc;
                                    cnt_d   = 4'd1;
                                    state_d = S_RDATA;
                                end else begin
                                    state_d = S_PTR;
                                end
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_RDATA_ACK;
                        end else begin
                            oe_d    = ~shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            shreg_d = rd_byte;
                            ptr_d   = ptr_inc;
                            cnt_d   = 4'd0;
                            state_d = S_RDATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_o   = 1'b0;
    assign sda_oe  = oe_q;
    assign busy    = (state_q != S_IDLE);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
